busy_vld_stim_checker: RTL and testbench

- Bench-side partner for a streaming dut that uses busy/vld point-to-point channels.
- Acts as producer on the 8-bit din channel: drives din_vld/din_data and obeys din_busy.
- Acts as consumer on the 11-bit dout channel: drives dout_busy and samples dout_vld/dout_data.
- Generates a deterministic sample stream, computes the expected sum of each GROUP_LEN-sample group, queues the expectations, compares each returned result, and reports pass/fail.

---
 rtl/busy_vld_stim_checker.sv | 204 ++++++++++++++++++++
 tb/tb_busy_vld_stim_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/busy_vld_stim_checker.sv
// busy_vld_stim_checker: drives a deterministic sample stream into a busy/vld dut and checks its per-group sums.
// Latency: first din_vld one cycle after start; done one cycle after the final dout transfer.
// Backpressure: din held while din_busy; a new group stalls while the expectation queue is full; dout_busy while queue empty.
// Optional: define BUSY_VLD_STIM_BACKPRESSURE_EN to add LFSR-driven random stalls on dout_busy.
module busy_vld_stim_checker #(
  parameter int DIN_W      = 8,
  parameter int DOUT_W     = 11,
  parameter int GROUP_LEN  = 8,
  parameter int NUM_GROUPS = 16,
  parameter int EXP_DEPTH  = 4,
  parameter int SEED       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              din_busy,
  output logic              din_vld,
  output logic [DIN_W-1:0]  din_data,
  output logic              dout_busy,
  input  logic              dout_vld,
  input  logic [DOUT_W-1:0] dout_data,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       grp_count
);

  localparam int PTR_W = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1;
  localparam int CNT_W = $clog2(EXP_DEPTH + 1);
  localparam int POS_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(GROUP_LEN - 1);
  localparam logic [15:0]      LAST_GRP = 16'(NUM_GROUPS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(EXP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(EXP_DEPTH - 1);
  localparam logic [DIN_W-1:0] SEED_V   = DIN_W'(SEED);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DIN_W-1:0]  smp_q, smp_d;          // next sample value
  logic [POS_W-1:0]  pos_q, pos_d;          // sample position inside the current group
  logic [15:0]       grp_idx_q, grp_idx_d;  // group currently being produced
  logic [DOUT_W-1:0] acc_q, acc_d;          // running sum of the current group
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       err_q, err_d;
  logic [15:0]       grp_q, grp_d;

  logic [DOUT_W-1:0] exp_mem [EXP_DEPTH];

  logic              start_run;
  logic              q_empty, q_full;
  logic              last_in_grp, last_smp;
  logic              din_xfer, dout_xfer;
  logic              push, pop;
  logic              dout_busy_base;
  logic [DOUT_W-1:0] grp_sum;

  assign start_run   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign q_empty     = (cnt_q == '0);
  assign q_full      = (cnt_q == FULL_CNT);
  assign last_in_grp = (pos_q == LAST_POS);
  assign last_smp    = last_in_grp && (grp_idx_q == LAST_GRP);

  // The full-queue stall only applies before the first sample of a group, so an
  // asserted din_vld can never be withdrawn: the count only drops while waiting.
  assign din_vld  = (state_q == S_RUN) && !((pos_q == '0) && q_full);
  assign din_data = din_vld ? smp_q : '0;
  assign din_xfer = din_vld && !din_busy;

  assign grp_sum = acc_q + {{(DOUT_W-DIN_W){1'b0}}, din_data};
  assign push    = din_xfer && last_in_grp;

  assign dout_busy_base = !((state_q == S_RUN || state_q == S_DRAIN) && !q_empty);

`ifdef BUSY_VLD_STIM_BACKPRESSURE_EN
  logic [7:0] lfsr_q;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) providing random sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign dout_busy = dout_busy_base || lfsr_q[0];
`else
  assign dout_busy = dout_busy_base;
`endif

  assign dout_xfer = dout_vld && !dout_busy;
  assign pop       = dout_xfer;

  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == 16'd0);
  assign err_count = err_q;
  assign grp_count = grp_q;

  // Datapath next-state: sample generation, group accumulation, expectation queue and scoring.
  always_comb begin
    smp_d     = smp_q;
    pos_d     = pos_q;
    grp_idx_d = grp_idx_q;
    acc_d     = acc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    grp_d     = grp_q;
    if (start_run) begin
      smp_d     = SEED_V;
      pos_d     = '0;
      grp_idx_d = '0;
      acc_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      err_d     = '0;
      grp_d     = '0;
    end else begin
      if (din_xfer) begin
        smp_d = smp_q + 1'b1;
        if (last_in_grp) begin
          pos_d     = '0;
          acc_d     = '0;
          grp_idx_d = grp_idx_q + 16'd1;
          wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
          acc_d = grp_sum;
        end
      end
      if (dout_xfer) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        grp_d    = grp_q + 16'd1;
        if (dout_data != exp_mem[rd_ptr_q] && err_q != 16'hFFFF) begin
          err_d = err_q + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Run-control FSM next state; DRAIN ends on the edge that pops the last expectation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (din_xfer && last_smp) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == '0) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      smp_q     <= SEED_V;
      pos_q     <= '0;
      grp_idx_q <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      grp_q     <= '0;
    end else begin
      state_q   <= state_d;
      smp_q     <= smp_d;
      pos_q     <= pos_d;
      grp_idx_q <= grp_idx_d;
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      grp_q     <= grp_d;
    end
  end

  // Expectation storage; entries are only meaningful between the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push && !start_run) begin
      exp_mem[wr_ptr_q] <= grp_sum;
    end
  end

endmodule

// File: tb/tb_busy_vld_stim_checker.sv
// tb_busy_vld_stim_checker: emulates a summing dut around the checker with random busy/vld timing.
// Latency: checks first din_vld one cycle after start and done one cycle after the final dout transfer.
// Backpressure: random din_busy, random dout_vld presentation, a directed busy hold and a queue-full stall.
module tb_busy_vld_stim_checker;

  localparam int DIN_W      = 8;
  localparam int DOUT_W     = 11;
  localparam int GROUP_LEN  = 8;
  localparam int NUM_GROUPS = 6;
  localparam int EXP_DEPTH  = 4;
  localparam int SEED       = 250;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              din_busy;
  logic              din_vld;
  logic [DIN_W-1:0]  din_data;
  logic              dout_busy;
  logic              dout_vld;
  logic [DOUT_W-1:0] dout_data;
  logic              done;
  logic              pass;
  logic [15:0]       err_count;
  logic [15:0]       grp_count;

  always #5 clk = ~clk;

  busy_vld_stim_checker #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .GROUP_LEN(GROUP_LEN),
    .NUM_GROUPS(NUM_GROUPS), .EXP_DEPTH(EXP_DEPTH), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .din_busy(din_busy), .din_vld(din_vld), .din_data(din_data),
    .dout_busy(dout_busy), .dout_vld(dout_vld), .dout_data(dout_data),
    .done(done), .pass(pass), .err_count(err_count), .grp_count(grp_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: sample n is (SEED+n) mod 256; a group's sum is the plain sum of its samples.
  function automatic int sample_of(input int n);
    return (SEED + n) % 256;
  endfunction

  function automatic int group_sum(input int g);
    int s = 0;
    for (int k = 0; k < GROUP_LEN; k++) s += sample_of(g * GROUP_LEN + k);
    return s;
  endfunction

  // Model / emulator state
  int          exp_n;
  int          emu_acc, emu_cnt, emu_grp;
  int          emu_q[$];
  bit          emu_bad_q[$];
  bit          emu_vld, emu_bad;
  logic [10:0] emu_dat;
  bit          emu_en, busy_rand;
  int          busy_hold;
  logic [31:0] corrupt_mask;
  int          ret_done, exp_err;
  bit          pend_out, hold_pend;
  logic [7:0]  hold_dat;

  task automatic model_reset();
    exp_n = 0; emu_acc = 0; emu_cnt = 0; emu_grp = 0;
    emu_q.delete(); emu_bad_q.delete();
    emu_vld = 0; emu_bad = 0; pend_out = 0; ret_done = 0; exp_err = 0; hold_pend = 0;
    dout_vld = 1'b0; dout_data = '0;
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_din_vld"},   din_vld,   0);
    chk({pfx, "_din_data"},  din_data,  0);
    chk({pfx, "_dout_busy"}, dout_busy, 1);
    chk({pfx, "_done"},      done,      0);
    chk({pfx, "_pass"},      pass,      0);
    chk({pfx, "_err"},       err_count, 0);
    chk({pfx, "_grp"},       grp_count, 0);
  endtask

  // One cycle: observe outputs at negedge, drive inputs for the next posedge.
  task automatic tick();
    @(negedge clk);
    if (pend_out) begin
      ret_done++;
      pend_out = 0;
      emu_vld  = 0;
    end
    chk("done_timing", done, (ret_done == NUM_GROUPS) ? 1 : 0);

    if (busy_hold > 0) begin
      din_busy = 1'b1;
      busy_hold--;
    end else begin
      din_busy = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (hold_pend) begin
      chk("hold_vld", din_vld, 1);
      chk("hold_dat", din_data, hold_dat);
    end
    hold_pend = 0;
    if (din_vld) begin
      if (din_busy) begin
        hold_pend = 1;
        hold_dat  = din_data;
      end else begin
        chk("din_data", din_data, sample_of(exp_n));
        exp_n++;
        emu_acc += din_data;
        emu_cnt++;
        if (emu_cnt == GROUP_LEN) begin
          chk("grp_sum", emu_acc, group_sum(emu_grp));
          emu_q.push_back(emu_acc);
          emu_bad_q.push_back(corrupt_mask[emu_grp]);
          emu_grp++;
          emu_acc = 0;
          emu_cnt = 0;
        end
      end
    end

    if (!emu_vld && emu_en && emu_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      emu_vld = 1;
      emu_dat = 11'(emu_q.pop_front());
      emu_bad = emu_bad_q.pop_front();
      if (emu_bad) emu_dat = emu_dat ^ 11'h001;
    end
    dout_vld  = emu_vld;
    dout_data = emu_vld ? emu_dat : 11'($urandom);
    if (emu_vld && !dout_busy) begin
      pend_out = 1;
      if (emu_bad) exp_err++;
    end
  endtask

  task automatic do_start();
    model_reset();
    @(negedge clk);
    start    = 1'b1;
    din_busy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_vld", din_vld, 1);
    chk("first_dat", din_data, SEED);
    chk("start_grp_clr", grp_count, 0);
    chk("start_err_clr", err_count, 0);
    chk("start_done_clr", done, 0);
    hold_pend = 1;
    hold_dat  = din_data;
  endtask

  task automatic run_to_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", done, 1);
    chk("grp_count", grp_count, NUM_GROUPS);
    chk("err_count", err_count, exp_err);
    chk("pass", pass, (exp_err == 0) ? 1 : 0);
    chk("din_total", exp_n, NUM_GROUPS * GROUP_LEN);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; din_busy = 1'b0;
    corrupt_mask = '0; emu_en = 1; busy_rand = 1; busy_hold = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Clean run with a directed 5-cycle din_busy hold at the start.
    do_start();
    busy_hold = 5;
    run_to_done(2000);
    repeat (3) tick();
    chk("done_held", done, 1);

    // Restart from DONE with groups 0 and 3 corrupted by the emulated dut.
    corrupt_mask = 32'b1001;
    do_start();
    run_to_done(2000);

    // Sink never accepts: the producer must stop after EXP_DEPTH full groups.
    corrupt_mask = '0;
    busy_rand = 0;
    emu_en = 0;
    do_start();
    repeat (GROUP_LEN * EXP_DEPTH + 20) tick();
    chk("stall_sent", exp_n, GROUP_LEN * EXP_DEPTH);
    chk("stall_din_vld", din_vld, 0);
    chk("stall_dout_busy", dout_busy, 0);
    chk("stall_done", done, 0);
    emu_en = 1;
    busy_rand = 1;
    run_to_done(2000);

    // Reset in the middle of a run, then a fresh run from SEED.
    do_start();
    begin
      int k = 0;
      while (exp_n < 5 && k < 500) begin
        tick();
        k++;
      end
      chk("mid_sent", exp_n, 5);
    end
    @(negedge clk);
    dout_vld = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    do_start();
    run_to_done(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
